// File: rtl/plab2_proc_imem_squash_unit_pkg.sv
// rtl/plab2_proc_imem_squash_unit_pkg.sv - shared constants and helpers for the imem squash unit
//
// Purpose: default imem response width (VC_MEM_RESP_MSG_NBITS(8,32)) and a
// circular-index helper used by the response buffer.
package plab2_proc_imem_squash_unit_pkg;

  localparam int c_imem_resp_msg_nbits = 45;

  // Advance a circular buffer index, wrapping to zero after depth-1.
  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned depth);
    return (idx + 1 >= depth) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/plab2_proc_squash_queue.sv
// rtl/plab2_proc_squash_queue.sv - bypass response FIFO with synchronous clear
//
// Purpose: holds imem responses that fetch could not accept yet. When empty,
// an incoming response is presented on the dequeue side in the same cycle.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   clear               drop every stored entry at the next edge
//   enq_val/rdy/msg     enqueue side (from memory)
//   deq_val/rdy/msg     dequeue side (to fetch)
//   full                all p_buf_depth entries occupied
module plab2_proc_squash_queue
  import plab2_proc_imem_squash_unit_pkg::*;
#(
  parameter int p_msg_nbits = c_imem_resp_msg_nbits,
  parameter int p_buf_depth = 2
)(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   enq_val,
  output logic                   enq_rdy,
  input  logic [p_msg_nbits-1:0] enq_msg,
  output logic                   deq_val,
  input  logic                   deq_rdy,
  output logic [p_msg_nbits-1:0] deq_msg,
  output logic                   full
);

  localparam int c_ptr_nbits = (p_buf_depth > 1) ? $clog2(p_buf_depth) : 1;
  localparam int c_cnt_nbits = $clog2(p_buf_depth + 1);

  logic [p_msg_nbits-1:0] entries [p_buf_depth];
  logic [c_ptr_nbits-1:0] head;
  logic [c_ptr_nbits-1:0] tail;
  logic [c_cnt_nbits-1:0] count;
  logic                   empty;
  logic                   do_enq;
  logic                   do_deq;

  assign empty   = (count == '0);
  assign full    = (count == c_cnt_nbits'(p_buf_depth));
  assign enq_rdy = !full;

  // Empty buffer: the incoming response passes straight through.
  assign deq_val = empty ? enq_val : 1'b1;
  assign deq_msg = empty ? enq_msg : entries[head];

  assign do_deq = !empty && deq_rdy;
  // A bypassed response that fetch takes immediately is never stored.
  assign do_enq = enq_val && enq_rdy && !(empty && deq_rdy);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (do_enq) tail <= c_ptr_nbits'(wrap_inc(32'(tail), p_buf_depth));
      if (do_deq) head <= c_ptr_nbits'(wrap_inc(32'(head), p_buf_depth));
      count <= count + c_cnt_nbits'(do_enq) - c_cnt_nbits'(do_deq);
    end
  end

  always_ff @(posedge clk) begin
    if (do_enq && !clear) entries[tail] <= enq_msg;
  end

endmodule

// File: rtl/plab2_proc_imem_squash_unit.sv
// rtl/plab2_proc_imem_squash_unit.sv - imem request limiter and stale-response squasher
//
// Purpose: sits between fetch and instruction memory, caps outstanding
// requests at p_max_inflight and, on squash, discards the responses of every
// request issued in earlier cycles while flushing its own response buffer.
// Ports:
//   clk, reset                           clock, synchronous active-high reset
//   squash                               redirect: drop older responses
//   proc_req_val/rdy, mem_req_val/rdy    request handshake fetch -> imem
//   mem_resp_msg/val/rdy                 response from imem
//   proc_resp_msg/val/rdy                response to fetch
//   inflight_count, drop_count           status counters
module plab2_proc_imem_squash_unit
  import plab2_proc_imem_squash_unit_pkg::*;
#(
  parameter int p_msg_nbits    = c_imem_resp_msg_nbits,
  parameter int p_max_inflight = 4,
  parameter int p_buf_depth    = 2,
  localparam int c_cnt_nbits   = $clog2(p_max_inflight + 1)
)(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   squash,
  input  logic                   proc_req_val,
  output logic                   proc_req_rdy,
  output logic                   mem_req_val,
  input  logic                   mem_req_rdy,
  input  logic [p_msg_nbits-1:0] mem_resp_msg,
  input  logic                   mem_resp_val,
  output logic                   mem_resp_rdy,
  output logic [p_msg_nbits-1:0] proc_resp_msg,
  output logic                   proc_resp_val,
  input  logic                   proc_resp_rdy,
  output logic [c_cnt_nbits-1:0] inflight_count,
  output logic [c_cnt_nbits-1:0] drop_count
);

  logic                   can_issue;
  logic                   req_fire;
  logic                   resp_fire;
  logic                   resp_dec;
  logic                   dropping;
  logic                   q_enq_val;
  logic                   q_enq_rdy;
  logic                   q_deq_val;
  logic                   q_full;
  logic [c_cnt_nbits-1:0] inflight_next;
  logic [c_cnt_nbits-1:0] drop_next;

  assign can_issue    = (inflight_count < c_cnt_nbits'(p_max_inflight));
  assign mem_req_val  = proc_req_val && can_issue && !reset;
  assign proc_req_rdy = mem_req_rdy && can_issue;
  assign req_fire     = mem_req_val && mem_req_rdy;

  // While discarding, responses are always sunk. Otherwise the bypass only
  // applies to an empty buffer, so "not full" already covers it.
  assign dropping     = (drop_count != '0) || squash;
  assign mem_resp_rdy = !reset && (dropping || q_enq_rdy);
  assign resp_fire    = mem_resp_val && mem_resp_rdy;
  // A response with nothing outstanding is a protocol error; it must not wrap the counter.
  assign resp_dec     = resp_fire && (inflight_count != '0);

  assign q_enq_val     = mem_resp_val && !dropping && !reset;
  assign proc_resp_val = q_deq_val && !squash && !reset;

  plab2_proc_squash_queue #(
    .p_msg_nbits (p_msg_nbits),
    .p_buf_depth (p_buf_depth)
  ) resp_queue (
    .clk     (clk),
    .reset   (reset),
    .clear   (squash),
    .enq_val (q_enq_val),
    .enq_rdy (q_enq_rdy),
    .enq_msg (mem_resp_msg),
    .deq_val (q_deq_val),
    .deq_rdy (proc_resp_rdy && !squash),
    .deq_msg (proc_resp_msg),
    .full    (q_full)
  );

  always_comb begin
    inflight_next = inflight_count;
    if (req_fire && !resp_dec)      inflight_next = inflight_count + 1'b1;
    else if (!req_fire && resp_dec) inflight_next = inflight_count - 1'b1;
  end

  // On squash every request still outstanding (other than the one answered
  // now) becomes stale; recomputing rather than adding avoids double counting.
  always_comb begin
    drop_next = drop_count;
    if (squash)                               drop_next = inflight_count - c_cnt_nbits'(resp_dec);
    else if (resp_fire && drop_count != '0)   drop_next = drop_count - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      inflight_count <= '0;
      drop_count     <= '0;
    end else begin
      inflight_count <= inflight_next;
      drop_count     <= drop_next;
    end
  end

  resp_without_request : assert property (@(posedge clk) disable iff (reset)
    !(resp_fire && inflight_count == '0));

  // Full flag is only needed inside the queue's ready computation.
  logic unused_full;
  assign unused_full = q_full;

endmodule

// File: tb/tb_plab2_proc_imem_squash_unit.sv
// tb/tb_plab2_proc_imem_squash_unit.sv - randomized self-checking bench for the imem squash unit
module tb_plab2_proc_imem_squash_unit;

  localparam int MSG   = 45;
  localparam int MAXI  = 4;
  localparam int DEPTH = 2;

  logic           clk = 1'b0;
  logic           reset;
  logic           squash;
  logic           proc_req_val;
  logic           proc_req_rdy;
  logic           mem_req_val;
  logic           mem_req_rdy;
  logic [MSG-1:0] mem_resp_msg;
  logic           mem_resp_val;
  logic           mem_resp_rdy;
  logic [MSG-1:0] proc_resp_msg;
  logic           proc_resp_val;
  logic           proc_resp_rdy;
  logic [2:0]     inflight_count;
  logic [2:0]     drop_count;

  plab2_proc_imem_squash_unit #(
    .p_msg_nbits    (MSG),
    .p_max_inflight (MAXI),
    .p_buf_depth    (DEPTH)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .squash         (squash),
    .proc_req_val   (proc_req_val),
    .proc_req_rdy   (proc_req_rdy),
    .mem_req_val    (mem_req_val),
    .mem_req_rdy    (mem_req_rdy),
    .mem_resp_msg   (mem_resp_msg),
    .mem_resp_val   (mem_resp_val),
    .mem_resp_rdy   (mem_resp_rdy),
    .proc_resp_msg  (proc_resp_msg),
    .proc_resp_val  (proc_resp_val),
    .proc_resp_rdy  (proc_resp_rdy),
    .inflight_count (inflight_count),
    .drop_count     (drop_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Stimulus knobs
  logic r_reset = 1'b1, r_squash = 1'b0, r_preq = 1'b0, r_mreq_rdy = 1'b1, r_presp_rdy = 1'b1, hold = 1'b0;
  int   lat_min = 1, lat_max = 1, cyc = 0;
  logic [31:0] next_addr = 32'h200;
  int   seq = 0;

  // Reference model: one flag per outstanding request (1 = its response is stale),
  // the fetch-side response buffer, and the memory's pending responses.
  bit             outq[$];
  logic [MSG-1:0] bufq[$];
  logic [MSG-1:0] pend_msg[$];
  int             pend_rdy[$];
  int             n_fired = 0, n_deliv = 0, n_dropped = 0, max_if = 0;
  logic [MSG-1:0] last_deliv = '0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic step();
    int             nd;
    bit             dropping, e_mrv, e_prq, e_mrr, e_prv, resp_fire, req_fire, keep, was_empty;
    logic [MSG-1:0] e_prm;
    @(negedge clk);
    if (r_reset) begin
      pend_msg.delete();
      pend_rdy.delete();
    end
    reset         = r_reset;
    squash        = r_squash;
    proc_req_val  = r_preq;
    mem_req_rdy   = r_mreq_rdy;
    proc_resp_rdy = r_presp_rdy;
    mem_resp_val  = !hold && pend_msg.size() > 0 && pend_rdy[0] <= cyc;
    mem_resp_msg  = mem_resp_val ? pend_msg[0] : MSG'({$urandom, $urandom});
    #1;
    if (r_reset) begin
      check("reset_mem_req_val", mem_req_val, 0);
      check("reset_proc_resp_val", proc_resp_val, 0);
      outq.delete();
      bufq.delete();
    end else begin
      nd = 0;
      foreach (outq[i]) if (outq[i]) nd++;
      dropping = nd > 0 || r_squash;
      e_mrv    = r_preq && outq.size() < MAXI;
      e_prq    = r_mreq_rdy && outq.size() < MAXI;
      e_mrr    = dropping || bufq.size() < DEPTH;
      e_prv    = 0;
      e_prm    = '0;
      if (!r_squash) begin
        if (bufq.size() > 0) begin
          e_prv = 1;
          e_prm = bufq[0];
        end else if (mem_resp_val && !dropping) begin
          e_prv = 1;
          e_prm = mem_resp_msg;
        end
      end
      check("mem_req_val", mem_req_val, e_mrv);
      check("proc_req_rdy", proc_req_rdy, e_prq);
      check("mem_resp_rdy", mem_resp_rdy, e_mrr);
      check("proc_resp_val", proc_resp_val, e_prv);
      if (e_prv) check("proc_resp_msg", proc_resp_msg, e_prm);
      check("inflight_count", inflight_count, outq.size());
      check("drop_count", drop_count, nd);
      if (int'(inflight_count) > max_if) max_if = int'(inflight_count);

      resp_fire = mem_resp_val && e_mrr;
      req_fire  = e_mrv && r_mreq_rdy;
      keep      = 0;
      was_empty = bufq.size() == 0;
      if (resp_fire) begin
        keep = !outq[0] && !r_squash;
        void'(outq.pop_front());
        void'(pend_msg.pop_front());
        void'(pend_rdy.pop_front());
        if (!keep) n_dropped++;
      end
      if (r_squash) begin
        bufq.delete();
        foreach (outq[i]) outq[i] = 1;
      end else begin
        if (e_prv && r_presp_rdy) begin
          n_deliv++;
          last_deliv = e_prm;
          if (!was_empty) void'(bufq.pop_front());
        end
        if (keep && !(was_empty && r_presp_rdy)) bufq.push_back(mem_resp_msg);
      end
      if (req_fire) begin
        outq.push_back(0);
        pend_msg.push_back({13'(seq), next_addr});
        pend_rdy.push_back(cyc + $urandom_range(lat_max, lat_min));
        seq++;
        next_addr += 32'd4;
        n_fired++;
      end
    end
    cyc++;
  endtask

  task automatic drain(input int n);
    r_preq = 0; r_squash = 0; hold = 0; r_presp_rdy = 1; r_mreq_rdy = 1; lat_min = 1; lat_max = 1;
    repeat (n) step();
  endtask

  task automatic peek_drop(input string nm, input int exp);
    @(posedge clk);
    #1;
    check(nm, drop_count, exp);
  endtask

  initial begin
    int base, base2;
    reset = 1; squash = 0; proc_req_val = 0; mem_req_rdy = 1; proc_resp_rdy = 1;
    mem_resp_val = 0; mem_resp_msg = '0;

    // Reset state
    r_reset = 1;
    repeat (2) step();
    r_reset = 0;
    step();
    check("init_inflight", inflight_count, 0);
    check("init_drop", drop_count, 0);
    check("init_mem_resp_rdy", mem_resp_rdy, 1);

    // 1-cycle memory, no squash, three fetches
    drain(4);
    next_addr = 32'h200; max_if = 0; base = n_deliv;
    r_preq = 1;
    repeat (3) step();
    r_preq = 0;
    repeat (4) step();
    check("t1_deliveries", n_deliv - base, 3);
    check("t1_last_addr", last_deliv[31:0], 32'h208);
    check("t1_max_inflight_le1", max_if <= 1, 1);

    // Stalled memory: cap at four outstanding
    drain(4);
    hold = 1; r_preq = 1; base = n_fired;
    repeat (6) step();
    check("t2_fired", n_fired - base, 4);
    check("t2_proc_req_rdy_capped", proc_req_rdy, 0);
    drain(20);

    // Squash with three in flight while a new request to 0x300 fires
    hold = 1; lat_min = 2; lat_max = 2; r_preq = 1;
    repeat (3) step();
    next_addr = 32'h300; r_squash = 1;
    step();
    r_squash = 0; r_preq = 0;
    peek_drop("t3_drop_count", 3);
    base = n_deliv; base2 = n_dropped; hold = 0;
    repeat (20) step();
    check("t3_deliveries", n_deliv - base, 1);
    check("t3_delivered_addr", last_deliv[31:0], 32'h300);
    check("t3_dropped", n_dropped - base2, 3);

    // Squash in the same cycle a response arrives, two in flight
    drain(4);
    hold = 1; r_preq = 1;
    repeat (2) step();
    r_preq = 0; hold = 0; r_squash = 1;
    step();
    check("t4_proc_resp_val", proc_resp_val, 0);
    check("t4_resp_accepted", mem_resp_rdy, 1);
    r_squash = 0;
    peek_drop("t4_drop_count", 1);
    drain(10);

    // Buffer fills under fetch backpressure, then squash clears it
    r_presp_rdy = 0; r_preq = 1;
    repeat (3) step();
    r_preq = 0;
    step();
    check("t5_backpressure", mem_resp_rdy, 0);
    r_squash = 1;
    step();
    r_squash = 0;
    step();
    check("t5_val_after_squash", proc_resp_val, 0);
    drain(10);

    // Reset with a full buffer and requests outstanding
    r_presp_rdy = 0; r_preq = 1;
    repeat (3) step();
    hold = 1;
    step();
    r_preq = 0; r_reset = 1;
    step();
    r_reset = 0; hold = 0; r_presp_rdy = 1;
    step();
    check("t6_inflight", inflight_count, 0);
    check("t6_drop", drop_count, 0);
    check("t6_proc_resp_val", proc_resp_val, 0);
    check("t6_mem_resp_rdy", mem_resp_rdy, 1);

    // Randomized traffic
    lat_min = 1; lat_max = 4;
    for (int i = 0; i < 3000; i++) begin
      r_preq      = 1'($urandom_range(0, 1));
      r_mreq_rdy  = ($urandom_range(0, 3) != 0);
      r_presp_rdy = ($urandom_range(0, 2) != 0);
      r_squash    = ($urandom_range(0, 11) == 0);
      r_reset     = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 19) == 0) hold = !hold;
      step();
    end
    r_reset = 0;
    drain(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
